// File: rtl/inv_mix_columns_seq.sv
// Column-serial AES InvMixColumns: latches a 128-bit round state on Start and
// streams one transformed column per cycle into a downstream column register.
module inv_mix_columns_seq (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         Start,
   input  logic [127:0] State_In,
   output logic [31:0]  Col_Out,
   output logic [1:0]   Col_Sel,
   output logic         Col_Load,
   output logic         Busy,
   output logic         Done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state, state_next;
   logic [1:0]    idx, idx_next;
   logic [127:0]  hold, hold_next;
   logic [31:0]   col_word;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // Each coefficient is built from the x2/x4/x8 chain of the same byte.
   function automatic logic [31:0] inv_mix_word(input logic [31:0] w);
      logic [7:0] s  [0:3];
      logic [7:0] x2 [0:3];
      logic [7:0] x4 [0:3];
      logic [7:0] x8 [0:3];
      logic [7:0] m9 [0:3];
      logic [7:0] mb [0:3];
      logic [7:0] md [0:3];
      logic [7:0] me [0:3];
      for (int i = 0; i < 4; i++) begin
         s[i]  = w[31-8*i -: 8];
         x2[i] = xtime(s[i]);
         x4[i] = xtime(x2[i]);
         x8[i] = xtime(x4[i]);
         m9[i] = x8[i] ^ s[i];
         mb[i] = x8[i] ^ x2[i] ^ s[i];
         md[i] = x8[i] ^ x4[i] ^ s[i];
         me[i] = x8[i] ^ x4[i] ^ x2[i];
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

   assign col_word = hold[{idx, 5'b00000} +: 32];

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state <= IDLE;
         idx   <= 2'd0;
         hold  <= '0;
      end else begin
         state <= state_next;
         idx   <= idx_next;
         hold  <= hold_next;
      end
   end

   // Start is a request, not a handshake: it is taken only in IDLE on a rising
   // edge, and any Start seen in RUN or DONE is dropped, never queued.
   always_comb begin
      state_next = state;
      idx_next   = idx;
      hold_next  = hold;
      Col_Out    = '0;
      Col_Sel    = 2'd0;
      Col_Load   = 1'b0;
      Busy       = (state != IDLE);
      Done       = 1'b0;
      case (state)
         IDLE: begin
            if (Start) begin
               hold_next  = State_In;
               idx_next   = 2'd0;
               state_next = RUN;
            end
         end
         RUN: begin
            Col_Load = 1'b1;
            Col_Sel  = idx;
            Col_Out  = inv_mix_word(col_word);
            idx_next = idx + 2'd1;
            if (idx == 2'd3) state_next = DONE;
         end
         DONE: begin
            Done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: doc/inv_mix_columns_seq.md
# inv_mix_columns_seq

Column-serial InvMixColumns engine for the AES decryption datapath. It accepts a 128-bit round state, transforms one 32-bit column per cycle over GF(2^8), and drives the column-select write port of the downstream 128-bit column register. That register receives word 0 at Select 00 into bits [31:0], through word 3 at Select 11 into bits [127:96]. Done tells the round controller that the column register holds the complete InvMixColumns result.

## Interface
- No parameters; all widths fixed.
- Clk  input  1  sole clock; all state updates on rising edge
- Reset  input  1  synchronous, active-low (Reset == 0 at a rising edge resets)
- Start  input  1  request; accepted only in IDLE
- State_In  input  128  round state; word k = State_In[32k+31:32k]; sampled on the accepting edge only
- Col_Out  output  32  transformed column k; drives column register Reg_In
- Col_Sel  output  2  column index k; drives column register Select
- Col_Load  output  1  column write strobe; drives column register load
- Busy  output  1  high whenever state != IDLE
- Done  output  1  one-cycle pulse; all four columns have been written

## Operation
- Byte order within a word: s0 = [31:24], s1 = [23:16], s2 = [15:8], s3 = [7:0]. Output bytes use the same positions.
- Transform, with all products in GF(2^8) modulo x^8+x^4+x^3+x+1 and all sums as XOR:
  - s0' = 0e·s0 ^ 0b·s1 ^ 0d·s2 ^ 09·s3
  - s1' = 09·s0 ^ 0e·s1 ^ 0b·s2 ^ 0d·s3
  - s2' = 0d·s0 ^ 09·s1 ^ 0e·s2 ^ 0b·s3
  - s3' = 0b·s0 ^ 0d·s1 ^ 09·s2 ^ 0e·s3
- Implement the products with xtime chains; no lookup ROM.
- State machine (3 states):
  - IDLE: if Start, latch State_In into a 128-bit holding register, clear idx to 0, go to RUN.
  - RUN: Col_Load = 1, Col_Sel = idx, Col_Out = transform(hold word idx). Then idx++. When idx == 3, go to DONE (idx wraps to 0).
  - DONE: Done = 1 for exactly this cycle; unconditionally go to IDLE.
- Start outside IDLE (in RUN or DONE) is ignored, not queued.
- State_In changes after the accepting edge have no effect on the operation in flight.
- Col_Out, Col_Sel and Col_Load are derived from flops only (state, idx, hold register), never directly from inputs.
- Reset (Reset == 0 at a rising edge), including mid-RUN, sets:
  - state = IDLE, idx = 0, hold register = 0
  - Col_Load = 0, Col_Sel = 0, Col_Out = 0, Busy = 0, Done = 0
- Any columns already written downstream before reset are left as-is; this block does not clear them.

## Timing
- Let E0 be the edge where Start is accepted.
- Cycles 1–4 (after E0 through E3): Col_Load = 1, Col_Sel = 0, 1, 2, 3 in order, on consecutive cycles, no gaps.
- The column register captures column k at the edge ending cycle k+1.
- Cycle 5: Done = 1, Col_Load = 0, Busy = 1. The column register holds the full result from this cycle on.
- Cycle 6: IDLE, Busy = 0.
- Earliest next acceptance is the edge ending cycle 6. Start-to-Done latency is 5 cycles; minimum throughput is one state per 6 cycles.
- Reset values: all outputs 0.
- Outputs while IDLE: Col_Out = 0, Col_Sel = 0, Col_Load = 0.

## Test plan
- Single column vectors. Load each word into word 0 (all other words 0), pulse Start, check Col_Out in cycle 1:
  - 8e4da1bc -> db135345
  - 9fdc589d -> f20a225c
  - 4d7ebdf8 -> 2d26314c
  - d5d5d7d6 -> d4d4d4d5
  - Also check words 1–3 give Col_Out = 0.
- Full state: State_In = {c6c6c6c6, 01010101, 8e4da1bc, 9fdc589d} for words 3..0. Expect:
  - Col_Sel sequence 0, 1, 2, 3 with Col_Load high for exactly 4 cycles
  - Col_Out = f20a225c, db135345, 01010101, c6c6c6c6
  - Done pulses in cycle 5 only; the downstream column register model matches.
- Start held high continuously, with State_In changed every cycle: only the words present at E0 are output. The next acceptance occurs at the edge ending cycle 6, and Done pulses once per 6 cycles.
- Reset driven to 0 during cycle 2 of RUN: the next cycle shows Col_Load = 0, Busy = 0, Done = 0, Col_Out = 0. Done is never asserted for the aborted operation, and a fresh Start afterwards completes normally.
- Reset held at 0 with Start = 1: every output stays 0 and no Col_Load occurs.
- Randomized check: 1000 random states compared against a reference InvMixColumns model; additionally verify that InvMixColumns of MixColumns(x) equals x for all four columns.
